baud_gen_frac: RTL

- Runtime-programmable fractional-N baud generator; next generation of the fixed-divisor baud tick generator.
- One instance drives both UART TX and RX:
  - oversample tick (os_tick);
  - derived 1x bit tick (bit_tick);
  - mid-bit sample strobe (mid_tick).
- Divisor is loaded from the UART config registers without resynthesis. A resync input aligns phase to an RX start-bit edge.

---
 rtl/baud_gen_frac.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: runtime-programmable fractional-N baud generator.
// Produces an oversample tick, a 1x bit tick and a mid-bit strobe for a UART.
// Build option: define BAUD_GEN_FRAC_EN to enable the fractional accumulator;
// without it every oversample interval is exactly the clamped integer divisor.
// Each interval's length is fixed when the interval starts, so a divisor change
// (deferred or immediate) only ever affects intervals that start afterwards.
module baud_gen_frac #(
  parameter int                DIV_W            = 16,
  parameter int                FRAC_W           = 4,
  parameter int                OVERSAMPLE       = 16,
  parameter logic [DIV_W-1:0]  DEFAULT_DIV_INT  = 27,
  parameter logic [FRAC_W-1:0] DEFAULT_DIV_FRAC = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          resync,
  input  logic                          cfg_load,
  input  logic [DIV_W-1:0]              div_int,
  input  logic [FRAC_W-1:0]             div_frac,
  output logic                          os_tick,
  output logic                          bit_tick,
  output logic                          mid_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
  output logic                          cfg_pending
);

  localparam int                PH_W      = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0]   PH_MID_M1 = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [DIV_W-1:0]  DEF_DI    = (DEFAULT_DIV_INT < DIV_W'(2)) ? DIV_W'(2) : DEFAULT_DIV_INT;
  // The first interval after reset starts with acc=0, and 0 + frac never carries.
  localparam logic [DIV_W-1:0]  DEF_PER_M1 = DEF_DI - DIV_W'(1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] per_m1;
  logic [DIV_W-1:0] act_int;
  logic [DIV_W-1:0] sh_int;

  logic             tick_now;
  logic             activate;
  logic [DIV_W-1:0] new_int;
  logic [DIV_W-1:0] new_di;
  logic [DIV_W-1:0] start_per_m1;

  // Decide whether this edge closes an interval and which divisor governs the next one
  always_comb begin
    tick_now = en && !resync && (cnt == per_m1);
    activate = cfg_pending && (tick_now || !en || resync);
    new_int  = activate ? sh_int : act_int;
    new_di   = (new_int < DIV_W'(2)) ? DIV_W'(2) : new_int;
  end

`ifdef BAUD_GEN_FRAC_EN
  logic [FRAC_W-1:0] act_frac;
  logic [FRAC_W-1:0] sh_frac;
  logic [FRAC_W-1:0] acc_next;
  logic [FRAC_W-1:0] new_frac;
  logic [FRAC_W-1:0] acc_base;
  logic [FRAC_W:0]   frac_sum;

  // Length of an interval starting now: integer part plus the accumulator carry
  always_comb begin
    new_frac     = activate ? sh_frac : act_frac;
    acc_base     = resync ? '0 : acc_next;
    frac_sum     = {1'b0, acc_base} + {1'b0, new_frac};
    start_per_m1 = new_di - DIV_W'(1) + DIV_W'(frac_sum[FRAC_W]);
  end

  // Fractional divisor registers; acc_next is the accumulator value committed at the interval's tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_frac <= DEFAULT_DIV_FRAC;
      sh_frac  <= DEFAULT_DIV_FRAC;
      acc_next <= DEFAULT_DIV_FRAC;
    end else begin
      if (activate) act_frac <= sh_frac;
      if (cfg_load) sh_frac <= div_frac;
      if (resync || tick_now) acc_next <= frac_sum[FRAC_W-1:0];
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^{div_frac, DEFAULT_DIV_FRAC};

  // Length of an interval starting now: always the clamped integer divisor
  always_comb begin
    start_per_m1 = new_di - DIV_W'(1);
  end
`endif

  // Integer divisor shadow/active pair; a capture on an activation edge stays pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_int     <= DEFAULT_DIV_INT;
      sh_int      <= DEFAULT_DIV_INT;
      cfg_pending <= 1'b0;
    end else begin
      if (activate) act_int <= sh_int;
      if (cfg_load) begin
        sh_int      <= div_int;
        cfg_pending <= 1'b1;
      end else if (activate) begin
        cfg_pending <= 1'b0;
      end
    end
  end

  // Interval counter, oversample phase and registered tick outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      per_m1   <= DEF_PER_M1;
      os_phase <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
    end else if (resync) begin
      cnt      <= '0;
      per_m1   <= start_per_m1;
      os_phase <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
    end else if (!en) begin
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
    end else if (tick_now) begin
      cnt      <= '0;
      per_m1   <= start_per_m1;
      os_phase <= os_phase + PH_W'(1);
      os_tick  <= 1'b1;
      bit_tick <= (os_phase == PH_LAST);
      mid_tick <= (os_phase == PH_MID_M1);
    end else begin
      cnt      <= cnt + DIV_W'(1);
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
    end
  end

endmodule
